// File: rtl/simple_fixed_point_signed_multiplier_if.sv
// Operand/result bundle for simple_fixed_point_signed_multiplier.
//   i_start        request strobe (sampled only while the multiplier is idle)
//   i_multiplicand signed operand A, Q(DATA_WIDTH-FRAC_BITS).FRAC_BITS
//   i_multiplier   signed operand B, same format
//   o_busy         operation in progress
//   o_done         one-cycle completion pulse
//   o_product      signed, rounded, saturated result (held until next done)
//   o_overflow     saturation flag for o_product
// master: the requester side; slave: the multiplier side.
interface simple_fixed_point_signed_multiplier_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  i_start;
  logic [DATA_WIDTH-1:0] i_multiplicand;
  logic [DATA_WIDTH-1:0] i_multiplier;
  logic                  o_busy;
  logic                  o_done;
  logic [DATA_WIDTH-1:0] o_product;
  logic                  o_overflow;

  modport master (
    output i_start, i_multiplicand, i_multiplier,
    input  o_busy, o_done, o_product, o_overflow
  );

  modport slave (
    input  i_start, i_multiplicand, i_multiplier,
    output o_busy, o_done, o_product, o_overflow
  );
endinterface

// File: rtl/simple_fixed_point_signed_multiplier.sv
// Iterative shift-and-add signed fixed-point multiplier.
// Operands are converted to magnitudes, multiplied one partial product per
// clock, then rounded half away from zero, rescaled by FRAC_BITS and
// saturated back to DATA_WIDTH bits.
//   i_clk    rising-edge clock
//   i_reset  synchronous active-high reset
//   bus      slave side of simple_fixed_point_signed_multiplier_if
// Latency from the accept edge to o_done is DATA_WIDTH+1 cycles; a new
// operation can be accepted every DATA_WIDTH+2 cycles.
module simple_fixed_point_signed_multiplier #(
  parameter int DATA_WIDTH = 8,
  parameter int FRAC_BITS  = 4
) (
  input  logic i_clk,
  input  logic i_reset,
  simple_fixed_point_signed_multiplier_if.slave bus
);

  localparam int AW = 2 * DATA_WIDTH;
  localparam int CW = $clog2(DATA_WIDTH + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [AW:0] ONE     = {{AW{1'b0}}, 1'b1};
  localparam logic [AW:0] HALF    = ONE << (FRAC_BITS - 1);
  localparam logic [AW:0] POS_LIM = (ONE << (DATA_WIDTH - 1)) - ONE;
  localparam logic [AW:0] NEG_LIM = ONE << (DATA_WIDTH - 1);

  localparam logic [DATA_WIDTH-1:0] SAT_POS = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic [DATA_WIDTH-1:0] SAT_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  logic [1:0]            state;
  logic [AW-1:0]         mcand;
  logic [DATA_WIDTH-1:0] mplier;
  logic [AW-1:0]         acc;
  logic [CW-1:0]         cnt;
  logic                  neg;

  logic [DATA_WIDTH-1:0] a_mag;
  logic [DATA_WIDTH-1:0] b_mag;
  logic [AW-1:0]         acc_next;
  logic [AW:0]           mag;
  logic [DATA_WIDTH-1:0] res_product;
  logic                  res_overflow;
  logic                  last_iter;

  // Magnitudes fit unsigned in DATA_WIDTH bits, including the most-negative value.
  always_comb begin
    a_mag = bus.i_multiplicand[DATA_WIDTH-1] ? ('0 - bus.i_multiplicand) : bus.i_multiplicand;
    b_mag = bus.i_multiplier[DATA_WIDTH-1]   ? ('0 - bus.i_multiplier)   : bus.i_multiplier;
  end

  assign last_iter = (cnt == CW'(DATA_WIDTH - 1));

  // Result is formed from the accumulator including the final partial
  // product, so it can be registered on the same edge that leaves RUN.
  always_comb begin
    acc_next = acc;
    if (mplier[0]) acc_next = acc + mcand;
    mag          = ({1'b0, acc_next} + HALF) >> FRAC_BITS;
    res_product  = neg ? ('0 - mag[DATA_WIDTH-1:0]) : mag[DATA_WIDTH-1:0];
    res_overflow = 1'b0;
    if (!neg && (mag > POS_LIM)) begin
      res_product  = SAT_POS;
      res_overflow = 1'b1;
    end else if (neg && (mag > NEG_LIM)) begin
      res_product  = SAT_NEG;
      res_overflow = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state          <= IDLE;
      mcand          <= '0;
      mplier         <= '0;
      acc            <= '0;
      cnt            <= '0;
      neg            <= 1'b0;
      bus.o_busy     <= 1'b0;
      bus.o_done     <= 1'b0;
      bus.o_product  <= '0;
      bus.o_overflow <= 1'b0;
    end else begin
      bus.o_done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.i_start) begin
            mcand      <= {{DATA_WIDTH{1'b0}}, a_mag};
            mplier     <= b_mag;
            neg        <= bus.i_multiplicand[DATA_WIDTH-1] ^ bus.i_multiplier[DATA_WIDTH-1];
            acc        <= '0;
            cnt        <= '0;
            bus.o_busy <= 1'b1;
            state      <= RUN;
          end
        end
        RUN: begin
          acc    <= acc_next;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 1'b1;
          if (last_iter) begin
            bus.o_product  <= res_product;
            bus.o_overflow <= res_overflow;
            state          <= DONE;
          end
        end
        DONE: begin
          // Done pulse is registered out of DONE so it lands DATA_WIDTH+1
          // cycles after accept, while IDLE may already take the next start.
          bus.o_done <= 1'b1;
          bus.o_busy <= 1'b0;
          state      <= IDLE;
        end
        default: begin
          bus.o_busy <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_simple_fixed_point_signed_multiplier.sv
module tb_simple_fixed_point_signed_multiplier;
  localparam int DW = 8;
  localparam int FB = 4;
  localparam int unsigned LAT = DW + 1;
  localparam int unsigned II  = DW + 2;

  typedef struct {
    logic [DW-1:0] prod;
    logic          ovf;
    int unsigned   acc_cycle;
  } exp_t;

  logic i_clk = 1'b0;
  logic i_reset;
  int unsigned cycle = 0;
  int unsigned n_checks = 0;
  int unsigned n_fails  = 0;
  exp_t sb[$];

  always #5 i_clk = ~i_clk;
  always @(posedge i_clk) cycle <= cycle + 1;

  simple_fixed_point_signed_multiplier_if #(.DATA_WIDTH(DW)) bus ();

  simple_fixed_point_signed_multiplier #(
    .DATA_WIDTH(DW),
    .FRAC_BITS (FB)
  ) dut (
    .i_clk  (i_clk),
    .i_reset(i_reset),
    .bus    (bus)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  // Monitor: pops one expectation per done pulse.
  always @(negedge i_clk) begin
    if (bus.o_done === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("product",  32'(bus.o_product), 32'(e.prod));
        check("overflow", 32'(bus.o_overflow), 32'(e.ovf));
        check("latency",  cycle - e.acc_cycle, LAT);
      end
    end
  end

  task automatic push_exp(input logic [DW-1:0] p, input logic o, input int unsigned acc);
    exp_t e;
    e.prod = p;
    e.ovf = o;
    e.acc_cycle = acc;
    sb.push_back(e);
  endtask

  // Called at a negedge with the DUT idle.
  task automatic run_op(input logic [DW-1:0] a, input logic [DW-1:0] b,
                        input logic [DW-1:0] p, input logic o);
    bus.i_start = 1'b1;
    bus.i_multiplicand = a;
    bus.i_multiplier = b;
    push_exp(p, o, cycle + 1);
    @(negedge i_clk);
    bus.i_start = 1'b0;
    bus.i_multiplicand = ~a;
    bus.i_multiplier = ~b;
    repeat (11) @(negedge i_clk);
  endtask

  logic [DW-1:0] vec_a [10] = '{8'h18, 8'hE8, 8'hE8, 8'h01, 8'hFF, 8'h01, 8'h7F, 8'h80, 8'h80, 8'h7F};
  logic [DW-1:0] vec_b [10] = '{8'h20, 8'h20, 8'hE0, 8'h08, 8'h08, 8'h07, 8'h7F, 8'h80, 8'h10, 8'h90};
  logic [DW-1:0] vec_p [10] = '{8'h30, 8'hD0, 8'h30, 8'h01, 8'hFF, 8'h00, 8'h7F, 8'h7F, 8'h80, 8'h80};
  logic          vec_o [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

  initial begin
    int unsigned acc0;
    i_reset = 1'b1;
    bus.i_start = 1'b0;
    bus.i_multiplicand = '0;
    bus.i_multiplier = '0;
    repeat (3) @(negedge i_clk);
    check("rst_busy",     32'(bus.o_busy), 32'd0);
    check("rst_done",     32'(bus.o_done), 32'd0);
    check("rst_product",  32'(bus.o_product), 32'd0);
    check("rst_overflow", 32'(bus.o_overflow), 32'd0);
    i_reset = 1'b0;
    @(negedge i_clk);

    // Directed products, rounding and saturation.
    for (int i = 0; i < 10; i++) run_op(vec_a[i], vec_b[i], vec_p[i], vec_o[i]);

    // Product and overflow hold after the last done.
    repeat (5) @(negedge i_clk);
    check("hold_product",  32'(bus.o_product), 32'h80);
    check("hold_overflow", 32'(bus.o_overflow), 32'd1);

    // Starts at E3 and E9 after accept are ignored.
    bus.i_start = 1'b1;
    bus.i_multiplicand = 8'h18;
    bus.i_multiplier = 8'h20;
    push_exp(8'h30, 1'b0, cycle + 1);
    @(negedge i_clk);
    bus.i_start = 1'b0;
    repeat (2) @(negedge i_clk);
    bus.i_start = 1'b1;
    bus.i_multiplicand = 8'h7F;
    bus.i_multiplier = 8'h7F;
    @(negedge i_clk);
    bus.i_start = 1'b0;
    check("busy_mid_run", 32'(bus.o_busy), 32'd1);
    repeat (5) @(negedge i_clk);
    bus.i_start = 1'b1;
    bus.i_multiplicand = 8'h80;
    bus.i_multiplier = 8'h10;
    @(negedge i_clk);
    bus.i_start = 1'b0;
    repeat (2) @(negedge i_clk);
    check("busy_after_ignored", 32'(bus.o_busy), 32'd0);
    repeat (8) @(negedge i_clk);
    check("hold_between_done", 32'(bus.o_product), 32'h30);

    // Held start: accepts every II cycles with the operands of each accept cycle.
    bus.i_start = 1'b1;
    bus.i_multiplicand = 8'hE8;
    bus.i_multiplier = 8'h20;
    acc0 = cycle + 1;
    push_exp(8'hD0, 1'b0, acc0);
    @(negedge i_clk);
    bus.i_multiplicand = 8'h01;
    bus.i_multiplier = 8'h08;
    push_exp(8'h01, 1'b0, acc0 + II);
    repeat (II) @(negedge i_clk);
    bus.i_multiplicand = 8'h7F;
    bus.i_multiplier = 8'h90;
    push_exp(8'h80, 1'b1, acc0 + 2 * II);
    repeat (II) @(negedge i_clk);
    bus.i_start = 1'b0;
    bus.i_multiplicand = 8'h00;
    bus.i_multiplier = 8'h00;
    repeat (12) @(negedge i_clk);

    // Reset during iteration 4 aborts the operation.
    bus.i_start = 1'b1;
    bus.i_multiplicand = 8'hE8;
    bus.i_multiplier = 8'hE0;
    @(negedge i_clk);
    bus.i_start = 1'b0;
    repeat (3) @(negedge i_clk);
    i_reset = 1'b1;
    @(negedge i_clk);
    i_reset = 1'b0;
    check("abort_busy",     32'(bus.o_busy), 32'd0);
    check("abort_done",     32'(bus.o_done), 32'd0);
    check("abort_product",  32'(bus.o_product), 32'd0);
    check("abort_overflow", 32'(bus.o_overflow), 32'd0);
    repeat (20) @(negedge i_clk);
    check("abort_idle_busy", 32'(bus.o_busy), 32'd0);
    run_op(8'hE8, 8'hE0, 8'h30, 1'b0);

    // Reset and start together: nothing accepted.
    i_reset = 1'b1;
    bus.i_start = 1'b1;
    bus.i_multiplicand = 8'h18;
    bus.i_multiplier = 8'h20;
    @(negedge i_clk);
    i_reset = 1'b0;
    bus.i_start = 1'b0;
    check("collide_busy0", 32'(bus.o_busy), 32'd0);
    @(negedge i_clk);
    check("collide_busy1", 32'(bus.o_busy), 32'd0);
    repeat (12) @(negedge i_clk);

    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
